// File: rtl/npu_pkg.sv
// Shared NPU widths, the LayerNorm row-scheduler state encoding and the engine command record.
package npu_pkg;

    localparam int ADDR_W = 16;
    localparam int CNT_W  = 16;
    localparam int PERF_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_DONE
    } ln_sched_state_t;

    typedef struct packed {
        cnt_t  length;
        addr_t src_base;
        addr_t dst_base;
        addr_t gamma_base;
        addr_t beta_base;
    } ln_eng_cmd_t;

endpackage

// File: rtl/ln_row_scheduler_if.sv
// Tile command, engine command and status bundle for ln_row_scheduler.
// perf_cycles/perf_stall exist only when LN_SCHED_PERF_EN is defined.
interface ln_row_scheduler_if;
    import npu_pkg::*;

    logic  cmd_valid;
    logic  cmd_ready;
    cnt_t  num_rows;
    cnt_t  hidden;
    addr_t src_base;
    addr_t dst_base;
    addr_t gamma_base;
    addr_t beta_base;
    addr_t row_stride;
    logic  abort;

    logic  eng_cmd_valid;
    logic  eng_cmd_ready;
    cnt_t  eng_length;
    addr_t eng_src_base;
    addr_t eng_dst_base;
    addr_t eng_gamma_base;
    addr_t eng_beta_base;
    logic  eng_done;

    logic  busy;
    logic  done;
    logic  err;
    logic  aborted;
    cnt_t  rows_done;
`ifdef LN_SCHED_PERF_EN
    logic [PERF_W-1:0] perf_cycles;
    logic [PERF_W-1:0] perf_stall;
`endif

    // Control unit plus engine side
    modport master (
        output cmd_valid, num_rows, hidden, src_base, dst_base, gamma_base, beta_base,
               row_stride, abort, eng_cmd_ready, eng_done,
        input  cmd_ready, eng_cmd_valid, eng_length, eng_src_base, eng_dst_base,
               eng_gamma_base, eng_beta_base, busy, done, err, aborted, rows_done
`ifdef LN_SCHED_PERF_EN
        , input perf_cycles, perf_stall
`endif
    );

    // Scheduler side
    modport slave (
        input  cmd_valid, num_rows, hidden, src_base, dst_base, gamma_base, beta_base,
               row_stride, abort, eng_cmd_ready, eng_done,
        output cmd_ready, eng_cmd_valid, eng_length, eng_src_base, eng_dst_base,
               eng_gamma_base, eng_beta_base, busy, done, err, aborted, rows_done
`ifdef LN_SCHED_PERF_EN
        , output perf_cycles, perf_stall
`endif
    );

endinterface

// File: rtl/ln_sched_perf_ctr.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module ln_sched_perf_ctr #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ln_row_scheduler.sv
// Walks a multi-row tile through the LayerNorm engine, one engine command per row.
// Define LN_SCHED_PERF_EN to add the busy-cycle and issue-stall counters.
module ln_row_scheduler
    import npu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    ln_row_scheduler_if.slave  bus
);

    ln_sched_state_t state, state_nxt;

    cnt_t        num_rows_q;
    cnt_t        row_idx;
    cnt_t        rows_done_q;
    addr_t       stride_q;
    ln_eng_cmd_t eng_q;
    logic        abort_flag;
    logic        err_q;

    logic accept;
    logic zero_size;
    logic last_row;
    logic in_tile;

    assign accept    = bus.cmd_valid && (state == S_IDLE);
    assign zero_size = (bus.num_rows == '0) || (bus.hidden == '0);
    assign last_row  = (row_idx == num_rows_q - cnt_t'(1));
    assign in_tile   = (state == S_ISSUE) || (state == S_WAIT) || (state == S_NEXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = zero_size ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A latched abort withdraws the command before any handshake.
                if (abort_flag) begin
                    state_nxt = S_DONE;
                end else if (bus.eng_cmd_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.eng_done) begin
                    state_nxt = (last_row || abort_flag) ? S_DONE : S_NEXT;
                end
            end
            S_NEXT:  state_nxt = S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // The engine fields double as the per-row cursors, so they are stable while valid is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_rows_q  <= '0;
            row_idx     <= '0;
            rows_done_q <= '0;
            stride_q    <= '0;
            eng_q       <= '0;
            abort_flag  <= 1'b0;
            err_q       <= 1'b0;
        end else if (accept) begin
            num_rows_q        <= bus.num_rows;
            row_idx           <= '0;
            rows_done_q       <= '0;
            stride_q          <= bus.row_stride;
            eng_q.length      <= bus.hidden;
            eng_q.src_base    <= bus.src_base;
            eng_q.dst_base    <= bus.dst_base;
            eng_q.gamma_base  <= bus.gamma_base;
            eng_q.beta_base   <= bus.beta_base;
            abort_flag        <= 1'b0;
            err_q             <= zero_size;
        end else begin
            if (in_tile && bus.abort) begin
                abort_flag <= 1'b1;
            end
            if ((state == S_WAIT) && bus.eng_done) begin
                rows_done_q <= rows_done_q + cnt_t'(1);
            end
            if (state == S_NEXT) begin
                row_idx        <= row_idx + cnt_t'(1);
                eng_q.src_base <= eng_q.src_base + stride_q;
                eng_q.dst_base <= eng_q.dst_base + stride_q;
            end
        end
    end

    assign bus.cmd_ready      = (state == S_IDLE);
    assign bus.eng_cmd_valid  = (state == S_ISSUE) && !abort_flag;
    assign bus.eng_length     = eng_q.length;
    assign bus.eng_src_base   = eng_q.src_base;
    assign bus.eng_dst_base   = eng_q.dst_base;
    assign bus.eng_gamma_base = eng_q.gamma_base;
    assign bus.eng_beta_base  = eng_q.beta_base;
    assign bus.busy           = (state != S_IDLE);
    assign bus.done           = (state == S_DONE);
    assign bus.err            = bus.done && err_q;
    assign bus.aborted        = bus.done && !err_q && (rows_done_q < num_rows_q);
    assign bus.rows_done      = rows_done_q;

`ifdef LN_SCHED_PERF_EN
    ln_sched_perf_ctr #(.W(PERF_W)) u_perf_cycles (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   (bus.busy),
        .count (bus.perf_cycles)
    );

    ln_sched_perf_ctr #(.W(PERF_W)) u_perf_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept),
        .inc   ((state == S_ISSUE) && !bus.eng_cmd_ready),
        .count (bus.perf_stall)
    );
`endif

endmodule

// File: tb/tb_ln_row_scheduler.sv
// Directed bench for ln_row_scheduler: tile-level row model, engine model with fixed latency.
module tb_ln_row_scheduler;
    import npu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ln_row_scheduler_if bus ();

    ln_row_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] len;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] g;
        logic [15:0] b;
    } row_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: expected engine commands of the current tile, in order, plus its ending
    row_t        exp_q[$];
    logic        exp_err = 1'b0;
    logic        exp_ab  = 1'b0;
    int          exp_rows = 0;
    logic [15:0] hs_src[$];

    // Engine control
    int lat        = 10;
    int abort_row  = -1;
    int stall_row  = -1;
    int stall_len  = 0;
    int stall_seen = 0;
    int hs_cnt     = 0;

    // Monitor bookkeeping
    int cyc = 0;
    int accept_edge = 0;
    int last_done_edge = 0;
    int done_edge = 0;
    int done_cnt = 0;
    int rises = 0;
    logic        d_err, d_ab;
    logic [15:0] d_rows;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine: takes commands, answers each with a done pulse lat cycles later
    initial begin
        bus.eng_cmd_ready = 1'b1;
        bus.eng_done      = 1'b0;
        bus.abort         = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.eng_cmd_valid && !bus.eng_cmd_ready) begin
                if (stall_seen >= stall_len) bus.eng_cmd_ready = 1'b1;
                else stall_seen++;
            end
            if (rst_n && bus.eng_cmd_valid && bus.eng_cmd_ready) begin
                int cur;
                hs_cnt++;
                cur = hs_cnt - 1;
                @(posedge clk); #1;
                if (hs_cnt == stall_row) begin
                    bus.eng_cmd_ready = 1'b0;
                    stall_seen = 0;
                end
                if (cur == abort_row) bus.abort = 1'b1;
                repeat (lat - 1) @(posedge clk);
                #1 bus.eng_done = 1'b1;
                @(posedge clk); #1;
                bus.eng_done = 1'b0;
                bus.abort    = 1'b0;
            end
        end
    end

    // Compare process, one sample per cycle after the falling edge
    initial begin
        logic        prev_valid, prev_hs, prev_done;
        logic [79:0] prev_f, f;
        row_t        e;
        prev_valid = 1'b0; prev_hs = 1'b0; prev_done = 1'b0; prev_f = '0;
        forever begin
            @(negedge clk); #1;
            if (!rst_n) begin
                prev_valid = 1'b0; prev_hs = 1'b0; prev_done = 1'b0;
                continue;
            end
            f = {bus.eng_length, bus.eng_src_base, bus.eng_dst_base, bus.eng_gamma_base, bus.eng_beta_base};
            chk("busy_vs_ready", 80'(bus.busy), 80'(!bus.cmd_ready));
            if (prev_done) chk("ready_after_done", 80'(bus.cmd_ready), 80'(1));
            if (bus.cmd_valid && bus.cmd_ready) begin
                accept_edge = cyc + 1;
                rises = 0;
            end
            if (bus.eng_cmd_valid && !prev_valid) begin
                chk("issue_time", 80'(cyc), 80'((rises == 0) ? accept_edge : last_done_edge + 1));
                rises++;
            end
            if (bus.eng_cmd_valid && prev_valid && !prev_hs) chk("fields_stable", f, prev_f);
            if (bus.eng_cmd_valid && bus.eng_cmd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 80'(1), 80'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("eng_length", 80'(bus.eng_length), 80'(e.len));
                    chk("eng_src",    80'(bus.eng_src_base), 80'(e.src));
                    chk("eng_dst",    80'(bus.eng_dst_base), 80'(e.dst));
                    chk("eng_gamma",  80'(bus.eng_gamma_base), 80'(e.g));
                    chk("eng_beta",   80'(bus.eng_beta_base), 80'(e.b));
                end
                hs_src.push_back(bus.eng_src_base);
            end
            if (bus.eng_done) last_done_edge = cyc + 1;
            if (bus.done) begin
                chk("done_time", 80'(cyc), 80'(exp_err ? accept_edge : last_done_edge));
                d_err  = bus.err;
                d_ab   = bus.aborted;
                d_rows = bus.rows_done;
                done_edge = cyc;
                done_cnt++;
            end else begin
                chk("err_idle", 80'({bus.err, bus.aborted}), 80'(0));
            end
            prev_valid = bus.eng_cmd_valid;
            prev_hs    = bus.eng_cmd_valid && bus.eng_cmd_ready;
            prev_done  = bus.done;
            prev_f     = f;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 80'(bus.cmd_ready), 80'(1));
        chk({tag, "_ctl"}, 80'({bus.eng_cmd_valid, bus.busy, bus.done, bus.err, bus.aborted}), 80'(0));
        chk({tag, "_rows_done"}, 80'(bus.rows_done), 80'(0));
        chk({tag, "_eng_fields"}, {bus.eng_length, bus.eng_src_base, bus.eng_dst_base,
                                   bus.eng_gamma_base, bus.eng_beta_base}, 80'(0));
    endtask

    task automatic load_model(input logic [15:0] nr, hid, src, dst, g, b, stride, input int ab);
        logic [15:0] s, d;
        int n;
        exp_err = (nr == 16'd0) || (hid == 16'd0);
        n = exp_err ? 0 : ((ab >= 0 && ab < int'(nr)) ? ab + 1 : int'(nr));
        s = src; d = dst;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{hid, s, d, g, b});
            s = s + stride;
            d = d + stride;
        end
        exp_rows = n;
        exp_ab = !exp_err && (n < int'(nr));
        hs_src.delete();
    endtask

    task automatic drive_cmd(input logic [15:0] nr, hid, src, dst, g, b, stride);
        @(posedge clk); #1;
        bus.num_rows = nr; bus.hidden = hid; bus.src_base = src; bus.dst_base = dst;
        bus.gamma_base = g; bus.beta_base = b; bus.row_stride = stride;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        // Fields must have been latched; garble the inputs
        bus.num_rows = 16'(1 + $urandom_range(7)); bus.hidden = 16'($urandom);
        bus.src_base = 16'($urandom); bus.dst_base = 16'($urandom);
        bus.gamma_base = 16'($urandom); bus.beta_base = 16'($urandom); bus.row_stride = 16'($urandom);
    endtask

    task automatic run_tile(input logic [15:0] nr, hid, src, dst, g, b, stride,
                            input int ab, input int st, input int sl);
        int start;
        load_model(nr, hid, src, dst, g, b, stride, ab);
        abort_row = ab; stall_row = st; stall_len = sl; hs_cnt = 0;
        start = done_cnt;
        drive_cmd(nr, hid, src, dst, g, b, stride);
        for (int k = 0; k < 3000 && done_cnt == start; k++) @(posedge clk);
        if (done_cnt == start) begin
            chk("done_timeout", 80'(0), 80'(1));
        end else begin
            chk("done_err", 80'(d_err), 80'(exp_err));
            chk("done_aborted", 80'(d_ab), 80'(exp_ab));
            chk("done_rows", 80'(d_rows), 80'(exp_rows));
        end
        chk("rows_left", 80'(exp_q.size()), 80'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.num_rows = '0; bus.hidden = '0; bus.src_base = '0;
        bus.dst_base = '0; bus.gamma_base = '0; bus.beta_base = '0; bus.row_stride = '0;

        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk); #2;
        check_reset_vals("post_reset");

        // Basic tile
        run_tile(16'd3, 16'd64, 16'h0100, 16'h0800, 16'h2000, 16'h3000, 16'd64, -1, -1, 0);
        chk("basic_src0", 80'(hs_src.size() > 0 ? hs_src[0] : 16'hDEAD), 80'(16'h0100));
        chk("basic_src1", 80'(hs_src.size() > 1 ? hs_src[1] : 16'hDEAD), 80'(16'h0140));
        chk("basic_src2", 80'(hs_src.size() > 2 ? hs_src[2] : 16'hDEAD), 80'(16'h0180));
        chk("basic_rows_lit", 80'(d_rows), 80'(3));
        chk("basic_rows_hold", 80'(bus.rows_done), 80'(3));

        // Zero-size rejects
        run_tile(16'd0, 16'd64, 16'h0100, 16'h0800, 16'h2000, 16'h3000, 16'd64, -1, -1, 0);
        chk("zero_rows_err_lit", 80'(d_err), 80'(1));
        run_tile(16'd5, 16'd0, 16'h0100, 16'h0800, 16'h2000, 16'h3000, 16'd64, -1, -1, 0);
        chk("zero_hidden_err_lit", 80'(d_err), 80'(1));
        chk("zero_hidden_rows", 80'(bus.rows_done), 80'(0));

        // Backpressure on row 1
        run_tile(16'd3, 16'd32, 16'h0400, 16'h0900, 16'h1111, 16'h2222, 16'h0080, -1, 1, 5);
        chk("bp_handshakes", 80'(hs_src.size()), 80'(3));
`ifdef LN_SCHED_PERF_EN
        chk("perf_stall", 80'(bus.perf_stall), 80'(5));
        chk("perf_cycles", 80'(bus.perf_cycles), 80'(done_edge - accept_edge + 1));
`endif

        // Abort during row 1 of a 4-row tile
        run_tile(16'd4, 16'd16, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0010, 1, -1, 0);
        chk("abort_rows_lit", 80'(d_rows), 80'(2));
        chk("abort_flag_lit", 80'(d_ab), 80'(1));

        // Address wrap
        run_tile(16'd2, 16'd8, 16'hFFC0, 16'h1000, 16'h0005, 16'h0006, 16'h0040, -1, -1, 0);
        chk("wrap_src1_lit", 80'(hs_src.size() > 1 ? hs_src[1] : 16'hDEAD), 80'(16'h0000));

        // Reset in the middle of a tile
        load_model(16'd3, 16'd64, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 16'd32, -1);
        abort_row = -1; stall_row = -1; hs_cnt = 0;
        drive_cmd(16'd3, 16'd64, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00, 16'd32);
        for (int k = 0; k < 50 && hs_cnt == 0; k++) @(posedge clk);
        chk("midreset_issued", 80'(hs_cnt), 80'(1));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_vals("midreset");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // The engine's stale done pulse arrives while idle and must be ignored
        repeat (15) @(posedge clk);
        #1 chk("stale_done_ignored", 80'({bus.rows_done, bus.busy}), 80'(0));

        run_tile(16'd2, 16'd128, 16'h0200, 16'h0600, 16'h0700, 16'h0900, 16'h0100, -1, -1, 0);
        chk("after_reset_src1", 80'(hs_src.size() > 1 ? hs_src[1] : 16'hDEAD), 80'(16'h0300));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
